goertzel_reg_bank: RTL and testbench

GOERTZEL_REG_BANK -- requirements
Module: goertzel_reg_bank

---
 rtl/goertzel_reg_bank.sv | 200 ++++++++++++++++++++
 tb/tb_goertzel_reg_bank.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_reg_bank.sv
// goertzel_reg_bank: AXI4-Lite register bank with VERSION, SCRATCH, N_RW control and N_RO status words.
// The read and write channels are independent FSMs, and every handshake output comes straight from a flop.
package goertzel_reg_bank_pkg;
    typedef struct packed {
        logic [31:0] awaddr;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wvalid;
        logic        bready;
        logic [31:0] araddr;
        logic        arvalid;
        logic        rready;
    } axi_lite_mosi;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rvalid;
    } axi_lite_miso;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

module goertzel_reg_bank
    import goertzel_reg_bank_pkg::*;
#(
    parameter int unsigned N_RW        = 4,
    parameter int unsigned N_RO        = 2,
    parameter logic [31:0] VERSION     = 32'h2904_2023,
    parameter logic [31:0] SCRATCH_RST = 32'hF0F0_F0F0,
    parameter logic [31:0] RW_RST      = 32'h0,
    localparam int unsigned N_RO_W     = (N_RO > 0) ? N_RO : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  axi_lite_mosi             axio_i,
    output axi_lite_miso             axii_o,
    output logic [N_RW*32-1:0]       rw_regs_o,
    output logic [N_RW-1:0]          wr_pulse_o,
    input  logic [N_RO_W*32-1:0]     ro_regs_i
);

    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;
    typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} w_state_e;

    r_state_e    r_state_q, r_state_d;
    w_state_e    w_state_q, w_state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [29:0] aw_word_q, aw_word_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] rw_q [N_RW];
    logic [31:0] rw_d [N_RW];
    logic [N_RW-1:0] wr_pulse_q, wr_pulse_d;

    logic [29:0] ar_word;
    logic        unused_inputs;

    // Byte lanes of address are don't-care; the status bus is idle when N_RO is zero.
    assign ar_word       = axio_i.araddr[31:2];
    assign unused_inputs = ^{axio_i.araddr[1:0], axio_i.awaddr[1:0], ro_regs_i};

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path through this block can infer a latch.
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (axio_i.arvalid) begin
                    r_state_d = R_DATA;
                    rdata_d   = '0;
                    rresp_d   = RESP_DECERR;
                    if (ar_word == 30'd0) begin
                        rdata_d = VERSION;
                        rresp_d = RESP_OKAY;
                    end else if (ar_word == 30'd1) begin
                        rdata_d = scratch_q;
                        rresp_d = RESP_OKAY;
                    end
                    for (int i = 0; i < N_RW; i++) begin
                        if (ar_word == 30'(2 + i)) begin
                            rdata_d = rw_q[i];
                            rresp_d = RESP_OKAY;
                        end
                    end
                    for (int j = 0; j < N_RO; j++) begin
                        if (ar_word == 30'(2 + N_RW + j)) begin
                            rdata_d = ro_regs_i[32*j +: 32];
                            rresp_d = RESP_OKAY;
                        end
                    end
                end
            end
            R_DATA: if (axio_i.rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d  = w_state_q;
        aw_word_d  = aw_word_q;
        bresp_d    = bresp_q;
        scratch_d  = scratch_q;
        rw_d       = rw_q;
        wr_pulse_d = '0;
        unique case (w_state_q)
            W_ADDR: begin
                if (axio_i.awvalid) begin
                    aw_word_d = axio_i.awaddr[31:2];
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axio_i.wvalid) begin
                    w_state_d = W_RESP;
                    bresp_d   = RESP_DECERR;
                    if (aw_word_q == 30'd1) begin
                        scratch_d = apply_strb(scratch_q, axio_i.wdata, axio_i.wstrb);
                        bresp_d   = RESP_OKAY;
                    end
                    for (int i = 0; i < N_RW; i++) begin
                        if (aw_word_q == 30'(2 + i)) begin
                            rw_d[i]       = apply_strb(rw_q[i], axio_i.wdata, axio_i.wstrb);
                            wr_pulse_d[i] = 1'b1;
                            bresp_d       = RESP_OKAY;
                        end
                    end
                end
            end
            W_RESP: if (axio_i.bready) w_state_d = W_ADDR;
            default: w_state_d = W_ADDR;
        endcase
    end

    // NOTE: all state uses <=, so a read decoded on the same edge as a write sees the pre-write value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q  <= R_IDLE;
            w_state_q  <= W_ADDR;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            bresp_q    <= RESP_OKAY;
            aw_word_q  <= '0;
            scratch_q  <= SCRATCH_RST;
            // NOTE: these are software-visible control flops, not RAM, so every entry is reset.
            rw_q       <= '{default: RW_RST};
            wr_pulse_q <= '0;
        end else begin
            r_state_q  <= r_state_d;
            w_state_q  <= w_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            bresp_q    <= bresp_d;
            aw_word_q  <= aw_word_d;
            scratch_q  <= scratch_d;
            rw_q       <= rw_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    always_comb begin
        axii_o         = '0;
        axii_o.arready = (r_state_q == R_IDLE);
        axii_o.rvalid  = (r_state_q == R_DATA);
        axii_o.rdata   = rdata_q;
        axii_o.rresp   = rresp_q;
        axii_o.awready = (w_state_q == W_ADDR);
        axii_o.wready  = (w_state_q == W_DATA);
        axii_o.bvalid  = (w_state_q == W_RESP);
        axii_o.bresp   = bresp_q;
    end

    always_comb begin
        rw_regs_o = '0;
        for (int i = 0; i < N_RW; i++) begin
            rw_regs_o[32*i +: 32] = rw_q[i];
        end
    end

    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_goertzel_reg_bank.sv
// Bench for goertzel_reg_bank: directed AXI4-Lite transactions, expected responses queued per channel
// and compared by independent R and B monitors.
module tb_goertzel_reg_bank;
    import goertzel_reg_bank_pkg::*;

    localparam int N_RW = 4;
    localparam int N_RO = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    axi_lite_mosi      axio_i;
    axi_lite_miso      axii_o;
    logic [N_RW*32-1:0] rw_regs_o;
    logic [N_RW-1:0]   wr_pulse_o;
    logic [N_RO*32-1:0] ro_regs_i;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    typedef struct {
        string      tag;
        logic [1:0] resp;
    } b_exp_t;

    r_exp_t r_q[$];
    b_exp_t b_q[$];

    always #5 clk = ~clk;

    goertzel_reg_bank #(.N_RW(N_RW), .N_RO(N_RO)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .axio_i     (axio_i),
        .axii_o     (axii_o),
        .rw_regs_o  (rw_regs_o),
        .wr_pulse_o (wr_pulse_o),
        .ro_regs_i  (ro_regs_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        r_exp_t e;
        if (rstn && axii_o.rvalid && axio_i.rready) begin
            check("r_transfer_expected", (r_q.size() != 0), 1);
            if (r_q.size() != 0) begin
                e = r_q.pop_front();
                check({e.tag, "_rdata"}, axii_o.rdata, e.data);
                check({e.tag, "_rresp"}, axii_o.rresp, e.resp);
            end
        end
    end

    always @(negedge clk) begin
        b_exp_t e;
        if (rstn && axii_o.bvalid && axio_i.bready) begin
            check("b_transfer_expected", (b_q.size() != 0), 1);
            if (b_q.size() != 0) begin
                e = b_q.pop_front();
                check({e.tag, "_bresp"}, axii_o.bresp, e.resp);
            end
        end
    end

    function automatic logic sel(input int w);
        case (w)
            0:       return axii_o.arready;
            1:       return axii_o.awready;
            default: return axii_o.wready;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where the selected ready is high.
    task automatic wait_sig(input string name, input int w);
        int n = 0;
        while (!sel(w) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check({name, "_ready_timeout"}, 0, 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((r_q.size() != 0 || b_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, r_q.size() + b_q.size(), 0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_d,
                      input logic [1:0] exp_r, input int stall, input bit flip_ro);
        r_q.push_back('{tag: tag, data: exp_d, resp: exp_r});
        @(posedge clk); #1;
        axio_i.araddr  = addr;
        axio_i.arvalid = 1'b1;
        axio_i.rready  = (stall == 0);
        @(negedge clk);
        wait_sig(tag, 0);
        @(posedge clk); #1;
        axio_i.arvalid = 1'b0;
        if (flip_ro) ro_regs_i = ~ro_regs_i;
        @(negedge clk);
        check({tag, "_rvalid_latency"}, axii_o.rvalid, 1);
        for (int i = 0; i < stall; i++) begin
            if (i > 0) @(negedge clk);
            check({tag, "_hold_rvalid"}, axii_o.rvalid, 1);
            check({tag, "_hold_rdata"}, axii_o.rdata, exp_d);
        end
        if (stall > 0) begin
            @(posedge clk); #1;
            axio_i.rready = 1'b1;
        end
        drain(tag);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [1:0] exp_r, input logic [N_RW-1:0] exp_pulse);
        b_q.push_back('{tag: tag, resp: exp_r});
        @(posedge clk); #1;
        axio_i.awaddr  = addr;
        axio_i.awvalid = 1'b1;
        @(negedge clk);
        wait_sig(tag, 1);
        @(posedge clk); #1;
        axio_i.awvalid = 1'b0;
        axio_i.wdata   = data;
        axio_i.wstrb   = strb;
        axio_i.wvalid  = 1'b1;
        @(negedge clk);
        wait_sig(tag, 2);
        @(posedge clk); #1;
        axio_i.wvalid = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, wr_pulse_o, exp_pulse);
        @(negedge clk);
        check({tag, "_pulse_gone"}, wr_pulse_o, 0);
        drain(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axio_i        = '0;
        axio_i.bready = 1'b1;
        axio_i.rready = 1'b1;
        ro_regs_i     = {32'hCAFE_0001, 32'h5A5A_A5A5};
        rstn          = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rvalid", axii_o.rvalid, 0);
        check("rst_bvalid", axii_o.bvalid, 0);
        check("rst_wready", axii_o.wready, 0);
        check("rst_pulse", wr_pulse_o, 0);
        check("rst_rw_regs", rw_regs_o, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_arready", axii_o.arready, 1);
        check("post_rst_awready", axii_o.awready, 1);

        rd("version", 32'h00, 32'h2904_2023, 2'b00, 0, 1'b0);

        wr("rw0_strb", 32'h08, 32'hDEAD_BEEF, 4'b0011, 2'b00, 4'b0001);
        check("rw0_port", rw_regs_o[31:0], 32'h0000_BEEF);
        rd("rw0_rd", 32'h08, 32'h0000_BEEF, 2'b00, 0, 1'b0);

        rd("scratch_stall", 32'h04, 32'hF0F0_F0F0, 2'b00, 5, 1'b0);

        wr("version_wr", 32'h00, 32'hFFFF_FFFF, 4'hF, 2'b11, 4'b0000);
        rd("unmapped_rd", 32'h100, 32'h0, 2'b11, 0, 1'b0);
        rd("version_again", 32'h00, 32'h2904_2023, 2'b00, 0, 1'b0);

        wr("scratch_wr", 32'h07, 32'h1122_3344, 4'b1100, 2'b00, 4'b0000);
        rd("scratch_rd", 32'h05, 32'h1122_F0F0, 2'b00, 0, 1'b0);

        // Status input flips right after the AR handshake; the held rdata must not follow it.
        rd("ro0_sample", 32'h18, 32'h5A5A_A5A5, 2'b00, 3, 1'b1);
        rd("ro1_rd", 32'h1C, 32'h3501_FFFE, 2'b00, 0, 1'b0);

        wr("ro_wr", 32'h18, 32'h0BAD_0BAD, 4'hF, 2'b11, 4'b0000);
        wr("past_end_wr", 32'h20, 32'h0BAD_0BAD, 4'hF, 2'b11, 4'b0000);
        rd("past_end_rd", 32'h20, 32'h0, 2'b11, 0, 1'b0);
        check("rw_after_bad_wr", rw_regs_o, {96'h0, 32'h0000_BEEF});

        wr("rw3_no_strb", 32'h14, 32'hFFFF_FFFF, 4'b0000, 2'b00, 4'b1000);
        rd("rw3_rd", 32'h14, 32'h0, 2'b00, 0, 1'b0);

        // Same-edge W and AR handshake on register 1.
        b_q.push_back('{tag: "same_edge_w", resp: 2'b00});
        r_q.push_back('{tag: "same_edge_r", data: 32'h0, resp: 2'b00});
        @(posedge clk); #1;
        axio_i.awaddr  = 32'h0C;
        axio_i.awvalid = 1'b1;
        @(negedge clk);
        wait_sig("same_edge_aw", 1);
        @(posedge clk); #1;
        axio_i.awvalid = 1'b0;
        axio_i.wdata   = 32'h1234_5678;
        axio_i.wstrb   = 4'hF;
        axio_i.wvalid  = 1'b1;
        axio_i.araddr  = 32'h0C;
        axio_i.arvalid = 1'b1;
        @(negedge clk);
        check("same_edge_wready", axii_o.wready, 1);
        check("same_edge_arready", axii_o.arready, 1);
        @(posedge clk); #1;
        axio_i.wvalid  = 1'b0;
        axio_i.arvalid = 1'b0;
        @(negedge clk);
        check("same_edge_pulse", wr_pulse_o, 4'b0010);
        check("same_edge_rvalid", axii_o.rvalid, 1);
        drain("same_edge");
        rd("same_edge_after", 32'h0C, 32'h1234_5678, 2'b00, 0, 1'b0);

        // Reset during W_DATA aborts the write to register 2.
        wr("rw2_pre", 32'h10, 32'hAAAA_5555, 4'hF, 2'b00, 4'b0100);
        @(posedge clk); #1;
        axio_i.awaddr  = 32'h10;
        axio_i.awvalid = 1'b1;
        @(negedge clk);
        wait_sig("abort_aw", 1);
        @(posedge clk); #1;
        axio_i.awvalid = 1'b0;
        axio_i.wdata   = 32'h1111_1111;
        axio_i.wstrb   = 4'hF;
        @(negedge clk);
        check("abort_in_wdata", axii_o.wready, 1);
        #1;
        rstn          = 1'b0;
        axio_i.wvalid = 1'b1;
        @(negedge clk);
        check("abort_rst_rw2", rw_regs_o[95:64], 32'h0);
        repeat (2) @(posedge clk);
        #1;
        axio_i.wvalid = 1'b0;
        rstn          = 1'b1;
        @(negedge clk);
        check("abort_bvalid", axii_o.bvalid, 0);
        check("abort_wready", axii_o.wready, 0);
        check("abort_awready", axii_o.awready, 1);
        check("abort_rw2", rw_regs_o[95:64], 32'h0);
        check("abort_pulse", wr_pulse_o, 0);
        repeat (3) @(negedge clk);
        check("abort_no_late_b", axii_o.bvalid, 0);
        rd("abort_rw2_rd", 32'h10, 32'h0, 2'b00, 0, 1'b0);
        rd("abort_rw0_rd", 32'h08, 32'h0, 2'b00, 0, 1'b0);
        rd("abort_scratch_rd", 32'h04, 32'hF0F0_F0F0, 2'b00, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
